// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Stores only have B/H/W forms; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic err;
    case (f3)
      F3_B, F3_BU: err = we && (f3 == F3_BU);
      F3_H, F3_HU: err = (we && (f3 == F3_HU)) || lo[0];
      F3_W:        err = (lo != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts/extends a load lane from a memory word
// and merges a byte/half store into the old word for read-modify-write.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int WIDTH1 = 32
) (
  input  logic [WIDTH1-1:0] word_i,
  input  logic [WIDTH1-1:0] wdata_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        funct3_i,
  output logic [WIDTH1-1:0] load_o,
  output logic [WIDTH1-1:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{lane_i, 3'b000} +: 8];
    half_v = word_i[{lane_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3_B:    load_o = {{(WIDTH1-8){byte_v[7]}}, byte_v};
      F3_BU:   load_o = {{(WIDTH1-8){1'b0}}, byte_v};
      F3_H:    load_o = {{(WIDTH1-16){half_v[15]}}, half_v};
      F3_HU:   load_o = {{(WIDTH1-16){1'b0}}, half_v};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (funct3_i)
      F3_B:    merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a word-addressed data memory without byte enables.
// Optional feature: define LSU_RANGE_CHECK_EN to reject word indices >= MEM_SIZE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH1   = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [WIDTH1-1:0] req_addr,
  input  logic [WIDTH1-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [WIDTH1-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [WIDTH1-1:0] mem_wdata,
  input  logic [WIDTH1-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH1-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once raised, resp_valid and all resp_* fields hold until that edge.

  state_e            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [WIDTH1-1:0] wdata_q;
  logic [WIDTH1-1:0] mem_addr_q;
  logic [WIDTH1-1:0] mem_wdata_q;
  logic [WIDTH1-1:0] resp_rdata_q;
  logic [4:0]        resp_rd_q;
  logic              resp_err_q;

  logic              req_err;
  logic [WIDTH1-1:0] load_word;
  logic [WIDTH1-1:0] merge_word;

  always_comb begin
    req_err = req_is_err(req_we, req_funct3, req_addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
    if ((req_addr >> 2) >= WIDTH1'(MEM_SIZE)) req_err = 1'b1;
`endif
  end

  // mem_rdata is only meaningful in S_RD, which is the only state using these.
  lsu_lane #(.WIDTH1(WIDTH1)) u_lane (
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            resp_rd_q    <= req_rd;
            mem_addr_q   <= {req_addr[WIDTH1-1:2], 2'b00};
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err) begin
              state_q <= S_RESP;
            end else if (req_we && (req_funct3 == F3_W)) begin
              mem_wdata_q <= req_wdata;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            mem_wdata_q <= merge_word;
            state_q     <= S_WR;
          end else begin
            resp_rdata_q <= load_word;
            state_q      <= S_RESP;
          end
        end
        S_WR:    state_q <= S_RESP;
        S_RESP:  if (resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_re     = (state_q == S_RD);
  assign mem_wr     = (state_q == S_WR);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, stall, mid-op reset,
// range check (LSU_RANGE_CHECK_EN aware) and random requests against a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;

  load_store_unit #(.WIDTH1(32), .MEM_SIZE(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- data memory + access monitor ----------------
  logic [31:0] dmem [1024];
  logic        loaded = 1'b0;
  int          re_total = 0;
  int          wr_total = 0;
  logic [31:0] last_re_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign mem_rdata = dmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'(i);
      loaded <= 1'b1;
    end else if (mem_wr) begin
      dmem[mem_addr[11:2]] <= mem_wdata;
    end
    if (mem_re) begin
      re_total++;
      last_re_addr = mem_addr;
    end
    if (mem_wr) begin
      wr_total++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level reference: memory is an array of words, lanes picked by shifting.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int lat, output int nre,
                                output int nwr, output logic [31:0] wword);
    int nb, sh, idx;
    logic [31:0] m, v;
    logic legal;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sh  = 8 * int'(addr % 4);
    idx = int'((addr / 4) % 1024);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || ((addr % nb) != 0);
`ifdef LSU_RANGE_CHECK_EN
    if ((addr / 4) >= 1024) err = 1'b1;
`endif
    rdata = '0; wword = '0; lat = 1; nre = 0; nwr = 0;
    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (err) return;
    if (!we) begin
      v = (ref_mem[idx] >> sh) & m;
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~m;
      rdata = v; lat = 2; nre = 1;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(m << sh)) | ((wdata & m) << sh);
      wword = ref_mem[idx];
      lat = (nb == 4) ? 2 : 3;
      nre = (nb == 4) ? 0 : 1;
      nwr = 1;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input int e_re, input int e_wr, input logic [31:0] e_wword,
                         input int hold);
    int re0, wr0, lat;
    @(negedge clk);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    re0 = re_total;
    wr0 = wr_total;
    exp_q.push_back(e_rdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(e_lat));
    check({name, " rdata"}, resp_rdata, exp_q.pop_front());
    check({name, " err"}, 32'(resp_err), 32'(e_err));
    check({name, " rd"}, 32'(resp_rd), 32'(rd));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = '0;
      @(posedge clk);
      #1;
      check({name, " hold valid"}, 32'(resp_valid), 32'd1);
      check({name, " hold rdata"}, resp_rdata, e_rdata);
      check({name, " hold ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({name, " post valid"}, 32'(resp_valid), 32'd0);
    check({name, " post ready"}, 32'(req_ready), 32'd1);
    check({name, " re cycles"}, 32'(re_total - re0), 32'(e_re));
    check({name, " wr cycles"}, 32'(wr_total - wr0), 32'(e_wr));
    if (e_re > 0) check({name, " re addr"}, last_re_addr, addr & ~32'd3);
    if (e_wr > 0) begin
      check({name, " wr addr"}, last_wr_addr, addr & ~32'd3);
      check({name, " wr data"}, last_wr_data, e_wword);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic [31:0] e_wword;
    logic        e_err;
    int          e_lat;
    int          e_re;
    int          e_wr;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] m_rdata, m_wword;
    logic        m_err;
    int          m_lat, m_re, m_wr;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    int          wr0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);

    tbl[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h0000_0004, 32'h0,          1'b0, 2, 1, 0};
    tbl[1]  = '{1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0,         32'hDEAD_BEEF,  1'b0, 2, 0, 1};
    tbl[2]  = '{1'b0, 3'b000, 32'h23, 32'h0,        32'hFFFF_FFDE, 32'h0,          1'b0, 2, 1, 0};
    tbl[3]  = '{1'b0, 3'b100, 32'h23, 32'h0,        32'h0000_00DE, 32'h0,          1'b0, 2, 1, 0};
    tbl[4]  = '{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF_DEAD, 32'h0,          1'b0, 2, 1, 0};
    tbl[5]  = '{1'b0, 3'b101, 32'h20, 32'h0,        32'h0000_BEEF, 32'h0,          1'b0, 2, 1, 0};
    tbl[6]  = '{1'b1, 3'b000, 32'h21, 32'h55,       32'h0,         32'hDEAD_55EF,  1'b0, 3, 1, 1};
    tbl[7]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hDEAD_55EF, 32'h0,          1'b0, 2, 1, 0};
    tbl[8]  = '{1'b0, 3'b010, 32'h22, 32'h0,        32'h0,         32'h0,          1'b1, 1, 0, 0};
    tbl[9]  = '{1'b1, 3'b001, 32'h21, 32'h1111,     32'h0,         32'h0,          1'b1, 1, 0, 0};
    tbl[10] = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,         32'h0,          1'b1, 1, 0, 0};
    tbl[11] = '{1'b1, 3'b001, 32'h22, 32'hABCD1234, 32'h0,         32'h1234_55EF,  1'b0, 3, 1, 1};
    tbl[12] = '{1'b0, 3'b001, 32'h20, 32'h0,        32'h0000_55EF, 32'h0,          1'b0, 2, 1, 0};
    tbl[13] = '{1'b0, 3'b000, 32'h21, 32'h0,        32'h0000_0055, 32'h0,          1'b0, 2, 1, 0};
    tbl[14] = '{1'b1, 3'b100, 32'h20, 32'h77,       32'h0,         32'h0,          1'b1, 1, 0, 0};
    tbl[15] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h1234_55EF, 32'h0,          1'b0, 2, 1, 0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst mem_re", 32'(mem_re), 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_rd", 32'(resp_rd), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat, m_re, m_wr, m_wword);
      run_req($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 5'(i + 1),
              tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_re, tbl[i].e_wr, tbl[i].e_wword, 0);
    end

    // ---- response stall with a competing request ----
    run_req("stall", 1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 32'h4, 1'b0, 2, 1, 0, 32'h0, 4);

    // ---- reset while an SB is in its read phase ----
    @(negedge clk);
    wr0 = wr_total;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h41; req_wdata = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midrst in RD", 32'(mem_re), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst ready", 32'(req_ready), 32'd1);
    check("midrst mem_re", 32'(mem_re), 32'd0);
    check("midrst mem_wr", 32'(mem_wr), 32'd0);
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst no write", 32'(wr_total - wr0), 32'd0);
    model(1'b0, 3'b010, 32'h40, 32'h0, m_rdata, m_err, m_lat, m_re, m_wr, m_wword);
    run_req("midrst word", 1'b0, 3'b010, 32'h40, 32'h0, 5'd3, 32'h0000_0010, 1'b0, 2, 1, 0, 32'h0, 0);

    // ---- range boundary: word index 1024 ----
    model(1'b0, 3'b010, 32'h1000, 32'h0, m_rdata, m_err, m_lat, m_re, m_wr, m_wword);
`ifdef LSU_RANGE_CHECK_EN
    run_req("range", 1'b0, 3'b010, 32'h1000, 32'h0, 5'd4, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
`else
    run_req("range", 1'b0, 3'b010, 32'h1000, 32'h0, 5'd4, 32'h0, 1'b0, 2, 1, 0, 32'h0, 0);
`endif

    // ---- randomized requests vs. model ----
    for (int i = 0; i < 200; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | 32'h1000;
      r_wdata = $urandom;
      model(r_we, r_f3, r_addr, r_wdata, m_rdata, m_err, m_lat, m_re, m_wr, m_wword);
      run_req($sformatf("rnd%0d", i), r_we, r_f3, r_addr, r_wdata, 5'($urandom_range(0, 31)),
              m_rdata, m_err, m_lat, m_re, m_wr, m_wword, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the word-addressed data memory; sits between execute stage and data memory, issues all load/store traffic.
- Accepts one request at a time: RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives word-aligned mem_addr with level re/wr; sign/zero-extends loads.
- Memory has no byte enables, so SB/SH use read-modify-write.

Parameters:
- WIDTH1, 32, data/address width.
- MEM_SIZE, 1024, data memory depth in words; used by the range check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 of load/store.
- req_addr  input  WIDTH1  byte address.
- req_wdata  input  WIDTH1  store data, right-aligned.
- req_rd  input  5  destination register tag, returned with response.
- mem_addr  output  WIDTH1  word-aligned byte address to memory.
- mem_re  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- mem_wdata  output  WIDTH1  full word to write.
- mem_rdata  input  WIDTH1  combinational read data, valid in the same cycle as mem_re.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  WIDTH1  extended load data; 0 for stores and errors.
- resp_rd  output  5  echoed tag.
- resp_err  output  1  misaligned address, illegal funct3 or out of range.

Behaviour:
- States: IDLE, RD, WR, RESP. Encoding is held in a state register; mem_re and mem_wr decode from state only, so they never glitch.
- Reset values: state = IDLE; req_ready = 1; mem_re = mem_wr = 0; mem_addr, mem_wdata, resp_rdata, resp_rd, resp_err = 0; resp_valid = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, funct3, we, wdata and rd.
  - Error check: illegal funct3; halfword with addr[0] = 1; word with addr[1:0] != 0.
  - On error, go to RESP with resp_err = 1. No memory access occurs.
  - Otherwise: load -> RD; SW -> WR; SB/SH -> RD.
- RD:
  - mem_re = 1; mem_addr = {addr[31:2], 2'b00}.
  - Capture mem_rdata at the clock edge.
  - Load -> RESP, with resp_rdata = selected lane, extended:
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Byte lane = addr[1:0]; half lane = addr[1].
  - SB/SH -> WR, with the merged word computed from the captured word.
- WR:
  - mem_wr = 1 for exactly one cycle; mem_addr and mem_wdata are held stable and come from registers.
  - SW writes wdata. SB/SH replace only the addressed lane with wdata[7:0] or wdata[15:0].
  - Next state RESP.
- RESP:
  - resp_valid = 1 and req_ready = 0.
  - resp_* fields are held stable until resp_valid && resp_ready, then go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency from acceptance edge to resp_valid:
  - LW/LB/LH/LBU/LHU: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Reset mid-operation: state returns to IDLE at that edge and mem_re/mem_wr are 0 the next cycle. A pending response is dropped. An RMW interrupted before WR leaves memory unmodified.
- Address width rule: only addr[1:0] selects a lane; upper bits pass through untouched.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: in IDLE, if (req_addr >> 2) >= MEM_SIZE, the request is treated as an error. It goes to RESP with resp_err = 1 and no mem_re/mem_wr pulse.
- Undefined: no range check; the address is passed through and the memory aliases or ignores it.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State localparams S_IDLE, S_RD, S_WR, S_RESP.
- One sub-module, lsu_lane: purely combinational.
  - Load extract/extend from word + addr[1:0] + funct3.
  - Store merge of old word + wdata + addr[1:0] + funct3.
  - Instantiated once; the FSM and registers stay in load_store_unit.

Test Plan:
- After reset (memory preload dmem[i] = i), LW addr 0x10 -> mem_re pulse with mem_addr 0x10; resp_rdata = 0x00000004 two cycles after acceptance; resp_err = 0.
- SW 0x20 data 0xDEADBEEF, then LB 0x23 -> 0xFFFFFFDE; LBU 0x23 -> 0x000000DE; LH 0x22 -> 0xFFFFDEAD; LHU 0x20 -> 0x0000BEEF.
- SB 0x21 data 0x55 (RMW) -> one mem_re cycle, then one mem_wr cycle with mem_wdata 0xDEAD55EF; a following LW 0x20 returns 0xDEAD55EF; latency 3.
- LW 0x22, SH 0x21, funct3 = 3'b011 -> resp_err = 1 after 1 cycle; mem_re and mem_wr never asserted; memory unchanged.
- resp_ready held 0 for 4 cycles after a LW -> resp_valid and resp_rdata are stable, req_ready = 0, and a second req_valid is not accepted until the handshake.
- Reset asserted while SB is in RD -> next cycle state is IDLE, mem_wr never pulses, target word is unchanged.
- With LSU_RANGE_CHECK_EN, LW 0x1000 (word 1024) -> resp_err = 1 with no memory access. Without the macro -> normal access.
